// File: rtl/mgr_mrc_pkg.sv
// Shared definitions for the WU-decoder to MRC descriptor receiver:
// beat control codes, option types, descriptor layout and FSM states.
package mgr_mrc_pkg;

  localparam int VALUE_W = 16;

  localparam logic [1:0] CNTL_MOM     = 2'b00;
  localparam logic [1:0] CNTL_SOM     = 2'b01;
  localparam logic [1:0] CNTL_EOM     = 2'b10;
  localparam logic [1:0] CNTL_SOM_EOM = 2'b11;

  typedef enum logic [2:0] {
    OPT_NOP       = 3'd0,
    OPT_CHAN      = 3'd1,
    OPT_BANK      = 3'd2,
    OPT_PAGE      = 3'd3,
    OPT_WORD      = 3'd4,
    OPT_NUM_LANES = 3'd5,
    OPT_STRIDE    = 3'd6
  } opt_type_e;

  typedef struct packed {
    logic [VALUE_W-1:0] chan;
    logic [VALUE_W-1:0] bank;
    logic [VALUE_W-1:0] page;
    logic [VALUE_W-1:0] word;
    logic [VALUE_W-1:0] num_lanes;
    logic [VALUE_W-1:0] stride;
  } desc_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DRAIN,
    ST_HOLD
  } state_e;

  localparam logic [VALUE_W-1:0] DEF_NUM_LANES = VALUE_W'(1);
  localparam logic [VALUE_W-1:0] DEF_STRIDE    = VALUE_W'(1);

  function automatic desc_t desc_defaults();
    desc_t d;
    d           = '0;
    d.num_lanes = DEF_NUM_LANES;
    d.stride    = DEF_STRIDE;
    return d;
  endfunction

endpackage

// File: rtl/mrc_desc_merge.sv
// Merges one beat's option pairs onto a descriptor. Pairs are applied in
// ascending index order so the highest index wins for a repeated type.
module mrc_desc_merge
  import mgr_mrc_pkg::*;
#(
  parameter int OPT_PER_INST = 3,
  parameter int OPT_TYPE_W   = 8
) (
  input  desc_t                                      base,
  input  logic [OPT_PER_INST-1:0][OPT_TYPE_W-1:0]    opt_type,
  input  logic [OPT_PER_INST-1:0][VALUE_W-1:0]       opt_value,
  output desc_t                                      merged,
  output logic                                       unknown
);

  always_comb begin
    merged  = base;
    unknown = 1'b0;
    for (int i = 0; i < OPT_PER_INST; i++) begin
      case (opt_type[i])
        OPT_TYPE_W'(OPT_NOP):       ;
        OPT_TYPE_W'(OPT_CHAN):      merged.chan      = opt_value[i];
        OPT_TYPE_W'(OPT_BANK):      merged.bank      = opt_value[i];
        OPT_TYPE_W'(OPT_PAGE):      merged.page      = opt_value[i];
        OPT_TYPE_W'(OPT_WORD):      merged.word      = opt_value[i];
        OPT_TYPE_W'(OPT_NUM_LANES): merged.num_lanes = opt_value[i];
        OPT_TYPE_W'(OPT_STRIDE):    merged.stride    = opt_value[i];
        default:                    unknown          = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/mrc_wud_desc_rx.sv
// MRC-side receiver: frames SOM..EOM option beats into one read descriptor
// and presents it on a registered valid/ready port with error pulses.
module mrc_wud_desc_rx
  import mgr_mrc_pkg::*;
#(
  parameter int OPT_PER_INST = 3,
  parameter int OPT_TYPE_W   = 8,
  parameter int OPT_VALUE_W  = VALUE_W,
  parameter int MAX_BEATS    = 8
) (
  input  logic                                    clk,
  input  logic                                    reset_poweron_n,
  input  logic                                    wud__mrc__valid,
  output logic                                    mrc__wud__ready,
  input  logic [1:0]                              wud__mrc__cntl,
  input  logic [OPT_PER_INST-1:0][OPT_TYPE_W-1:0] wud__mrc__option_type,
  input  logic [OPT_PER_INST-1:0][OPT_VALUE_W-1:0] wud__mrc__option_value,
  output logic                                    mrc__mrg__valid,
  input  logic                                    mrg__mrc__ready,
  output logic [OPT_VALUE_W-1:0]                  mrc__mrg__chan,
  output logic [OPT_VALUE_W-1:0]                  mrc__mrg__bank,
  output logic [OPT_VALUE_W-1:0]                  mrc__mrg__page,
  output logic [OPT_VALUE_W-1:0]                  mrc__mrg__word,
  output logic [OPT_VALUE_W-1:0]                  mrc__mrg__num_lanes,
  output logic [OPT_VALUE_W-1:0]                  mrc__mrg__stride,
  output logic                                    mrc__err_framing,
  output logic                                    mrc__err_unknown_opt,
  output logic                                    mrc__err_overrun
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  state_e           state, state_nxt;
  desc_t            acc, acc_nxt, hold, hold_nxt, out_q, out_nxt, base, merged;
  logic             out_vld, out_vld_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W:0]   cnt_inc;
  logic             beat, som, eom, unknown, slot_free, at_limit;
  logic             take, done;
  logic             err_fr_c, err_unk_c, err_ov_c;

  assign som       = wud__mrc__cntl[0];
  assign eom       = wud__mrc__cntl[1];
  // Gated by reset so the decoder never sees ready while the block is held.
  assign mrc__wud__ready = reset_poweron_n && (state != ST_HOLD);
  assign beat      = wud__mrc__valid && mrc__wud__ready;
  assign slot_free = !out_vld || mrg__mrc__ready;
  assign cnt_inc   = {1'b0, cnt} + 1'b1;
  assign at_limit  = cnt_inc >= (CNT_W+1)'(MAX_BEATS);
  assign base      = som ? desc_defaults() : acc;

  mrc_desc_merge #(
    .OPT_PER_INST (OPT_PER_INST),
    .OPT_TYPE_W   (OPT_TYPE_W)
  ) u_merge (
    .base      (base),
    .opt_type  (wud__mrc__option_type),
    .opt_value (wud__mrc__option_value),
    .merged    (merged),
    .unknown   (unknown)
  );

  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) state <= ST_IDLE;
    else                  state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:
        if (beat && som) state_nxt = eom ? (slot_free ? ST_IDLE : ST_HOLD) : ST_COLLECT;
      ST_COLLECT:
        if (beat) begin
          if (eom)                  state_nxt = slot_free ? ST_IDLE : ST_HOLD;
          else if (!som && at_limit) state_nxt = ST_DRAIN;
        end
      ST_DRAIN:
        if (beat) begin
          if (eom)      state_nxt = ST_IDLE;
          else if (som) state_nxt = ST_COLLECT;
        end
      ST_HOLD:
        if (slot_free) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // take: this beat is merged; done: it also completes the descriptor.
  always_comb begin
    acc_nxt     = acc;
    cnt_nxt     = cnt;
    hold_nxt    = hold;
    out_nxt     = out_q;
    out_vld_nxt = out_vld && !mrg__mrc__ready;
    take        = 1'b0;
    done        = 1'b0;
    err_fr_c    = 1'b0;
    err_unk_c   = 1'b0;
    err_ov_c    = 1'b0;
    unique case (state)
      ST_IDLE:
        if (beat) begin
          if (som) begin
            take = 1'b1;
            done = eom;
          end else begin
            err_fr_c = 1'b1;
          end
        end
      ST_COLLECT:
        if (beat) begin
          err_fr_c = som;
          if (som || eom || !at_limit) begin
            take = 1'b1;
            done = eom;
          end else begin
            err_ov_c = 1'b1;
          end
        end
      ST_DRAIN:
        if (beat && som && !eom) take = 1'b1;
      ST_HOLD:
        if (slot_free) begin
          out_nxt     = hold;
          out_vld_nxt = 1'b1;
        end
      default: ;
    endcase
    if (take) begin
      err_unk_c = unknown;
      if (done) begin
        acc_nxt = '0;
        cnt_nxt = '0;
        if (slot_free) begin
          out_nxt     = merged;
          out_vld_nxt = 1'b1;
        end else begin
          hold_nxt = merged;
        end
      end else begin
        acc_nxt = merged;
        cnt_nxt = som ? CNT_W'(1) : cnt_inc[CNT_W-1:0];
      end
    end
    if (err_ov_c) begin
      acc_nxt = '0;
      cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) begin
      acc                  <= '0;
      hold                 <= '0;
      out_q                <= '0;
      out_vld              <= 1'b0;
      cnt                  <= '0;
      mrc__err_framing     <= 1'b0;
      mrc__err_unknown_opt <= 1'b0;
      mrc__err_overrun     <= 1'b0;
    end else begin
      acc                  <= acc_nxt;
      hold                 <= hold_nxt;
      out_q                <= out_nxt;
      out_vld              <= out_vld_nxt;
      cnt                  <= cnt_nxt;
      mrc__err_framing     <= err_fr_c;
      mrc__err_unknown_opt <= err_unk_c;
      mrc__err_overrun     <= err_ov_c;
    end
  end

  assign mrc__mrg__valid     = out_vld;
  assign mrc__mrg__chan      = out_q.chan;
  assign mrc__mrg__bank      = out_q.bank;
  assign mrc__mrg__page      = out_q.page;
  assign mrc__mrg__word      = out_q.word;
  assign mrc__mrg__num_lanes = out_q.num_lanes;
  assign mrc__mrg__stride    = out_q.stride;

endmodule

// File: doc/mrc_wud_desc_rx.md
Name: mrc_wud_desc_rx

Overview:
- Memory-read-controller (MRC) side receiver for the WU decoder to MRC descriptor stream: valid/ready/cntl beats, each carrying OPT_PER_INST option type/value pairs.
- Frames beats SOM..EOM, decodes recognised option types into one memory-read descriptor, and presents it to the MRC read-request generator over a registered valid/ready port.
- Sits in each manager between the WU decoder and the MRC request path; detects framing errors and runaway descriptors.

Parameters:
- OPT_PER_INST, 3, option pairs per beat.
- OPT_TYPE_W, 8, width of an option type.
- OPT_VALUE_W, 16, width of an option value.
- MAX_BEATS, 8, beat limit per descriptor before abort (must be ≥ 1).

Ports:
- clk  in  1  clock
- reset_poweron_n  in  1  reset, asynchronous assert, active-low
- wud__mrc__valid  in  1  beat valid
- mrc__wud__ready  out  1  beat accepted when valid && ready
- wud__mrc__cntl  in  2  00=MOM, 01=SOM, 10=EOM, 11=SOM_EOM
- wud__mrc__option_type  in  [OPT_PER_INST] x OPT_TYPE_W  option types
- wud__mrc__option_value  in  [OPT_PER_INST] x OPT_VALUE_W  option values
- mrc__mrg__valid  out  1  descriptor valid
- mrg__mrc__ready  in  1  downstream accept
- mrc__mrg__chan  out  OPT_VALUE_W  target channel
- mrc__mrg__bank  out  OPT_VALUE_W  target bank
- mrc__mrg__page  out  OPT_VALUE_W  target page
- mrc__mrg__word  out  OPT_VALUE_W  target word
- mrc__mrg__num_lanes  out  OPT_VALUE_W  lanes to read
- mrc__mrg__stride  out  OPT_VALUE_W  word stride
- mrc__err_framing  out  1  one-cycle pulse on a framing error
- mrc__err_unknown_opt  out  1  one-cycle pulse on an unrecognised option type
- mrc__err_overrun  out  1  one-cycle pulse on a beat-limit abort

Behaviour:
- Reset (async, reset_poweron_n=0): state=IDLE; all outputs, accumulator and beat counter 0; mrc__wud__ready=0 while in reset.
- Option types: 0 NOP (ignored), 1 CHAN, 2 BANK, 3 PAGE, 4 WORD, 5 NUM_LANES, 6 STRIDE. Any other type is ignored and pulses err_unknown_opt.
- Precedence: within a beat, the higher index wins; across beats, the later beat wins.
- SOM loads accumulator defaults before merging the beat: chan/bank/page/word=0, num_lanes=1, stride=1.
- States:
  - IDLE, ready=1:
    - SOM → COLLECT, cnt=1.
    - SOM_EOM → complete.
    - MOM or EOM → beat dropped, err_framing, stay IDLE.
  - COLLECT, ready=1:
    - MOM → merge, cnt++.
    - EOM → merge, complete.
    - SOM → discard partial, err_framing, restart with this beat (cnt=1).
    - SOM_EOM → discard partial, err_framing, complete with this beat.
    - A MOM that would make cnt reach MAX_BEATS → abort: drop accumulator, err_overrun, DRAIN.
  - DRAIN, ready=1: discard beats until EOM or SOM_EOM is accepted → IDLE, with no descriptor output. A SOM in DRAIN restarts COLLECT.
  - HOLD, ready=0: a complete descriptor is waiting for the output slot. When the slot is free, load the output register → IDLE.
- Complete: if the output slot is free (!mrc__mrg__valid || mrg__mrc__ready) in the accept cycle, load the output register directly; mrc__mrg__valid is high the next cycle. Otherwise go to HOLD.
- Latency: EOM accepted in cycle N → mrc__mrg__valid in N+1 when not back-pressured.
- Output register holds fields stable while valid && !ready. Clear valid on a handshake unless reloaded in the same cycle.
- Throughput: back-to-back SOM_EOM beats sustain 1 descriptor per cycle when mrg__mrc__ready=1.
- Error pulses are registered and assert in the cycle after the offending beat is accepted. Several may assert together.
- Reset mid-descriptor discards everything; no partial output is ever emitted.

Decomposition:
- Shared package mgr_mrc_pkg: cntl encodings, option-type enum, descriptor struct (six fields), state enum, and the num_lanes/stride defaults.
- Sub-module mrc_desc_merge: combinational merge of one beat's option pairs onto the accumulator, with index precedence and an unknown-type flag. The FSM, counter and output register stay in the top level.

Test Plan:
- Single SOM_EOM beat {CHAN=2, PAGE=0x1A, NUM_LANES=4} with ready=1 → next cycle valid: chan=2, bank=0, page=0x1A, word=0, lanes=4, stride=1; no error pulses.
- Three beats SOM{BANK=1}, MOM{BANK=3, WORD=7}, EOM{STRIDE=2} with mrg__mrc__ready held 0 for 5 cycles:
  - bank=3, word=7, stride=2.
  - valid stays high and fields stay stable.
  - A following descriptor's EOM puts the block in HOLD with mrc__wud__ready=0 until the first descriptor is taken.
- EOM while IDLE, then SOM in COLLECT → err_framing pulses twice; only the restarted descriptor is output.
- MAX_BEATS=8: SOM + 7 MOM → err_overrun on the 7th MOM; subsequent beats dropped through EOM; no output; the next SOM_EOM is output normally.
- Beat {type 9, type 5=6, type 5=8} → err_unknown_opt pulses; num_lanes=8 (index 2 wins).
- Assert reset_poweron_n=0 after SOM → all outputs 0 immediately. After release, an EOM is a framing error.
